// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the cpu_ctrl instruction sequencer
package cpu_pkg;
    localparam int W = 16;

    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        DECODE    = 3'd1,
        WRITE_IMM = 3'd2,
        GET_A     = 3'd3,
        GET_B     = 3'd4,
        ALU       = 3'd5,
        WRITE_REG = 3'd6
    } state_t;

    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;

    // op field meaning under OP_MOV
    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;
endpackage

// File: rtl/cpu_ctrl_if.sv
// rtl/cpu_ctrl_if.sv - switch inputs and datapath/register-file controls of cpu_ctrl
interface cpu_ctrl_if;
    logic                  s;
    logic                  load;
    logic [cpu_pkg::W-1:0] in;
    logic                  w;
    logic [2:0]            readnum;
    logic [2:0]            writenum;
    logic                  write;
    logic                  loada;
    logic                  loadb;
    logic                  loadc;
    logic                  loads;
    logic                  asel;
    logic                  bsel;
    logic [1:0]            vsel;
    logic [1:0]            shift;
    logic [1:0]            ALUop;
    logic [cpu_pkg::W-1:0] sximm8;

    modport master (
        output s, load, in,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm8
    );

    modport slave (
        input  s, load, in,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop, sximm8
    );
endinterface

// File: rtl/cpu_instr_dec.sv
// rtl/cpu_instr_dec.sv - splits the instruction register into fields and sign-extends imm8
module cpu_instr_dec
    import cpu_pkg::*;
(
    input  logic [W-1:0] ir,
    output logic [2:0]   opcode,
    output logic [1:0]   op,
    output logic [2:0]   rn,
    output logic [2:0]   rd,
    output logic [1:0]   sh,
    output logic [2:0]   rm,
    output logic [W-1:0] sximm8
);
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(W-8){ir[7]}}, ir[7:0]};
endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - instruction register and Moore control FSM sequencing MOV/ADD/CMP/AND/MVN
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    cpu_ctrl_if.slave  bus
);
    state_t         state_q, state_d;
    logic [W-1:0]   ir_q, ir_d;
    logic [2:0]     opcode, rn, rd, rm;
    logic [1:0]     op, sh;
    logic [W-1:0]   sximm8;

    cpu_instr_dec u_dec (
        .ir     (ir_q),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // IR only loads while idle, so an executing instruction never sees its fields change
    always_comb begin
        ir_d = ir_q;
        if (state_q == WAIT && bus.load) ir_d = bus.in;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT:      if (bus.s) state_d = DECODE;
            DECODE: begin
                if (opcode == OP_MOV && op == MOV_IMM)      state_d = WRITE_IMM;
                else if (opcode == OP_MOV && op == MOV_REG) state_d = GET_B;
                else if (opcode == OP_ALU)                  state_d = GET_A;
                else                                        state_d = WAIT;
            end
            WRITE_IMM: state_d = WAIT;
            GET_A:     state_d = GET_B;
            GET_B:     state_d = ALU;
            ALU:       state_d = (opcode == OP_ALU && op == ALU_CMP) ? WAIT : WRITE_REG;
            WRITE_REG: state_d = WAIT;
            default:   state_d = WAIT;
        endcase
    end

    always_comb begin
        bus.w        = 1'b0;
        bus.readnum  = 3'd0;
        bus.writenum = 3'd0;
        bus.write    = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.vsel     = VSEL_C;
        bus.shift    = sh;
        bus.ALUop    = op;
        bus.sximm8   = sximm8;
        case (state_q)
            WAIT:      bus.w = 1'b1;
            WRITE_IMM: begin
                bus.writenum = rn;
                bus.write    = 1'b1;
                bus.vsel     = VSEL_IMM8;
            end
            GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
            end
            GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
            end
            ALU: begin
                // MOV register reuses the adder with A forced to zero
                bus.asel = (opcode == OP_MOV);
                if (opcode == OP_ALU && op == ALU_CMP) bus.loads = 1'b1;
                else                                   bus.loadc = 1'b1;
            end
            WRITE_REG: begin
                bus.writenum = rd;
                bus.write    = 1'b1;
                bus.vsel     = VSEL_C;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - self-checking bench for cpu_ctrl: vector table, corner sequences, random vs model
module tb_cpu_ctrl;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    cpu_ctrl_if bus ();
    cpu_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        int         nwr;
        logic [2:0] wnum;
        logic [1:0] vsel;
        logic [15:0] imm;
        int         na;
        logic [2:0] anum;
        int         nb;
        logic [2:0] bnum;
        logic [1:0] bsh;
        int         nc;
        int         ns;
        logic [1:0] aluop;
        logic       asel;
    } obs_t;

    typedef struct {
        logic [15:0] instr;
        int          lat;
        int          nwr;
        logic [2:0]  wnum;
        logic [1:0]  vsel;
        logic [15:0] imm;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Load and start in the same cycle, then summarise everything seen until w returns
    task automatic exec(input logic [15:0] instr, output obs_t o);
        o = '{default: 0};
        @(negedge clk);
        bus.in = instr; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0; bus.s = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.w) break;
            o.lat++;
            if (bus.write) begin
                o.nwr++; o.wnum = bus.writenum; o.vsel = bus.vsel; o.imm = bus.sximm8;
            end
            if (bus.loada) begin o.na++; o.anum = bus.readnum; end
            if (bus.loadb) begin o.nb++; o.bnum = bus.readnum; o.bsh = bus.shift; end
            if (bus.loadc) o.nc++;
            if (bus.loads) o.ns++;
            if (bus.loadc || bus.loads) begin o.aluop = bus.ALUop; o.asel = bus.asel; end
        end
    endtask

    function automatic obs_t model(input logic [15:0] i);
        obs_t        e   = '{default: 0};
        logic [2:0]  opc = i[15:13];
        logic [1:0]  op  = i[12:11];
        logic [15:0] sx  = 16'($signed(i[7:0]));
        if (opc == 3'b110 && op == 2'b10) begin
            e.lat = 2; e.nwr = 1; e.wnum = i[10:8]; e.vsel = 2'b10; e.imm = sx;
        end else if (opc == 3'b110 && op == 2'b00) begin
            e.lat = 4; e.nb = 1; e.bnum = i[2:0]; e.bsh = i[4:3];
            e.nc = 1; e.aluop = op; e.asel = 1'b1;
            e.nwr = 1; e.wnum = i[7:5]; e.vsel = 2'b00; e.imm = sx;
        end else if (opc == 3'b101) begin
            e.na = 1; e.anum = i[10:8]; e.nb = 1; e.bnum = i[2:0]; e.bsh = i[4:3];
            e.aluop = op; e.asel = 1'b0;
            if (op == 2'b01) begin
                e.lat = 4; e.ns = 1;
            end else begin
                e.lat = 5; e.nc = 1; e.nwr = 1; e.wnum = i[7:5]; e.vsel = 2'b00; e.imm = sx;
            end
        end else begin
            e.lat = 1;
        end
        return e;
    endfunction

    task automatic compare_obs(input logic [15:0] instr, input obs_t a, input obs_t e);
        string t;
        t = $sformatf("%h", instr);
        check({t, " latency"}, a.lat, e.lat);
        check({t, " writes"}, a.nwr, e.nwr);
        check({t, " writenum"}, a.wnum, e.wnum);
        check({t, " vsel"}, a.vsel, e.vsel);
        check({t, " sximm8"}, a.imm, e.imm);
        check({t, " loada"}, a.na, e.na);
        check({t, " readnum_a"}, a.anum, e.anum);
        check({t, " loadb"}, a.nb, e.nb);
        check({t, " readnum_b"}, a.bnum, e.bnum);
        check({t, " shift"}, a.bsh, e.bsh);
        check({t, " loadc"}, a.nc, e.nc);
        check({t, " loads"}, a.ns, e.ns);
        check({t, " ALUop"}, a.aluop, e.aluop);
        check({t, " asel"}, a.asel, e.asel);
    endtask

    initial begin
        obs_t        o;
        logic [15:0] instr;
        int          cnt_w, cnt_wr;

        vt[0] = '{16'hD007, 2, 1, 3'd0, 2'b10, 16'h0007};
        vt[1] = '{16'hD1FE, 2, 1, 3'd1, 2'b10, 16'hFFFE};
        vt[2] = '{16'hA148, 5, 1, 3'd2, 2'b00, 16'h0048};
        vt[3] = '{16'hA801, 4, 0, 3'd0, 2'b00, 16'h0000};
        vt[4] = '{16'hC040, 4, 1, 3'd2, 2'b00, 16'h0040};
        vt[5] = '{16'hB0E3, 5, 1, 3'd7, 2'b00, 16'hFFE3};
        vt[6] = '{16'hB8A2, 5, 1, 3'd5, 2'b00, 16'hFFA2};
        vt[7] = '{16'hE000, 1, 0, 3'd0, 2'b00, 16'h0000};
        vt[8] = '{16'hD800, 1, 0, 3'd0, 2'b00, 16'h0000};

        reset = 1'b1; bus.s = 1'b0; bus.load = 1'b0; bus.in = '0;
        #1;
        check("reset w", bus.w, 1'b1);
        check("reset write", bus.write, 1'b0);
        check("reset loads", {bus.loada, bus.loadb, bus.loadc, bus.loads}, 4'b0);
        check("reset sel", {bus.asel, bus.bsel, bus.vsel}, 4'b0);
        check("reset ir", bus.sximm8, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 9; k++) begin
            exec(vt[k].instr, o);
            check($sformatf("vec%0d latency", k), o.lat, vt[k].lat);
            check($sformatf("vec%0d writes", k), o.nwr, vt[k].nwr);
            if (vt[k].nwr > 0) begin
                check($sformatf("vec%0d writenum", k), o.wnum, vt[k].wnum);
                check($sformatf("vec%0d vsel", k), o.vsel, vt[k].vsel);
                check($sformatf("vec%0d sximm8", k), o.imm, vt[k].imm);
            end
        end

        // Reset while ADD sits in GET_B: abort immediately and never write
        @(negedge clk);
        bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1; bus.load = 1'b0; bus.s = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("getb loadb", bus.loadb, 1'b1);
        check("getb readnum", bus.readnum, 3'd0);
        check("getb shift", bus.shift, 2'b01);
        #2 reset = 1'b1;
        #1;
        check("abort w", bus.w, 1'b1);
        check("abort write", bus.write, 1'b0);
        check("abort ir", {bus.sximm8, bus.shift}, 18'h0);
        @(negedge clk); reset = 1'b0;
        cnt_wr = 0; cnt_w = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.write) cnt_wr++;
            if (bus.w) cnt_w++;
        end
        check("abort no write", cnt_wr, 0);
        check("abort idle", cnt_w, 8);

        // load while executing must not disturb the IR
        @(negedge clk);
        bus.in = 16'hA801; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1; bus.s = 1'b0; bus.in = 16'hD007; bus.load = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk); bus.load = 1'b0;
        cnt_wr = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.w) break;
            if (bus.write) cnt_wr++;
            @(negedge clk);
        end
        check("ignore load w", bus.w, 1'b1);
        check("ignore load write", cnt_wr, 0);
        check("ignore load sximm8", bus.sximm8, 16'h0001);
        check("ignore load ALUop", bus.ALUop, 2'b01);

        // s held high restarts as soon as WAIT is reached
        @(negedge clk);
        bus.in = 16'hD007; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1; bus.load = 1'b0;
        cnt_wr = 0; cnt_w = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.write) cnt_wr++;
            if (bus.w) cnt_w++;
        end
        bus.s = 1'b0;
        check("s held writes", cnt_wr, 2);
        check("s held idle", cnt_w, 2);
        repeat (3) @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    instr = {3'b110, 13'($urandom)};
                2:       instr = {3'b101, 13'($urandom)};
                default: instr = 16'($urandom);
            endcase
            exec(instr, o);
            compare_obs(instr, o, model(instr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
